booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised sequential Booth multiplier; next generation of the team's 16-bit datapath/controlpath Booth unit. Accepts a start pulse, captures multiplicand then multiplier serially on a shared `data_in` bus, iterates add/subtract/arithmetic-shift steps under a counter-driven FSM, and presents a double-width product with a sticky `done`. Adds width parametrisation, per-operation signed/unsigned mode, a `busy` flag, and optional radix-4 recoding.

## Interface
- `WIDTH`, 16, operand width in bits; even, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation; accepted only in IDLE or DONE.
- `sign_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with accepted `start`.
- `data_in`  in  WIDTH  multiplicand on the cycle after start, multiplier on the next.
- `busy`  out  1  high from start acceptance until DONE entered.
- `done`  out  1  high in DONE; held until next accepted start or reset.
- `product`  out  2*WIDTH  result; valid while `done`=1.

## Operation
- States: IDLE → LOAD_M → LOAD_Q → ITER → DONE.
- IDLE/DONE: `start`=1 at an edge → LOAD_M, latch `sign_mode`, clear A, Q, q(-1) and counter; `done` falls, `busy` rises.
- LOAD_M: capture `data_in` as M, extended (sign or zero per mode) to internal width WI. → LOAD_Q.
- LOAD_Q: capture `data_in` as Q, extended to WI; q(-1)=0; counter loaded with N. → ITER.
- Radix-2: WI = WIDTH+1, N = WIDTH+1. Per step: {q0,q(-1)} 01 → A+=M, 10 → A-=M, else none; then arithmetic shift right {A,Q,q(-1)} by 1.
- Radix-4 (macro on): WI = WIDTH+2, N = (WIDTH+2)/2. Per step: recode {q1,q0,q(-1)} to 0, ±M, ±2M; A carries one guard bit for 2M; arithmetic shift right by 2.
- Counter decrements each ITER step; on the step where it reaches zero (`eqz`) → DONE.
- `product` = low 2*WIDTH bits of {A,Q} after the last step; registered, updated on DONE entry only.
- `start` in LOAD_M/LOAD_Q/ITER ignored; `data_in` ignored outside LOAD_M/LOAD_Q.
- Reset (any state, mid-operation included): IDLE, `busy`=0, `done`=0, `product`=0, all internal registers 0.

## Timing
- Start sampled at edge T; M captured at T+1; Q at T+2; steps at T+3 … T+2+N; DONE entered at edge T+2+N.
- Latency start→done: N+2 edges. WIDTH=16: radix-2 = 19, radix-4 = 11.
- `busy` high after edge T through edge T+2+N (exclusive).
- Restart from DONE: `done` low after edge T; `product` holds old value until new DONE.
- Simultaneous reset and start: reset wins.

## Configuration
- `BOOTH_RADIX4_EN` defined: radix-4 recoding, N = (WIDTH+2)/2, extra guard bit in A.
- Undefined: radix-2 recoding, N = WIDTH+1. Interface, handshake and product identical in both builds; only latency differs.

## Structure
- Package `booth_pkg`: state encoding constants, `booth_iters(WIDTH)` function returning N, recode operation encoding (NONE, ADD1, SUB1, ADD2, SUB2).
- Sub-module `booth_recoder`: combinational, Q low bits + q(-1) → operation code and shifted multiple of M; instantiated once in the datapath.

## Test plan
- WIDTH=16, signed, M=-2 (0xFFFE), Q=2 → `product`=0xFFFFFFFC, `done` rises at edge T+19 (T+11 radix-4), `busy` low at the same edge.
- Unsigned, M=0xFFFF, Q=0xFFFF → 0xFFFE0001; same operands signed → 0x00000001.
- Signed, M=0x8000, Q=0x8000 → 0x40000000; M=0x8000, Q=0x7FFF → 0xC0008000.
- `start` pulsed during ITER → ignored, result and done timing unchanged; restart from DONE with M=3, Q=-5 → 0xFFFFFFF1.
- `reset` asserted mid-ITER → `busy`, `done`, `product` 0 immediately (asynchronously); next start completes correctly.
- WIDTH=8 and WIDTH=32 builds, random 1000 operands per mode vs. reference model, both macro settings.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared state/op encodings and radix-dependent sizing; BOOTH_RADIX4_EN selects radix-4.
package booth_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, ITER, DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD1, OP_SUB1, OP_ADD2, OP_SUB2} op_t;
`ifdef BOOTH_RADIX4_EN
  localparam int RADIX_SHIFT = 2;
`else
  localparam int RADIX_SHIFT = 1;
`endif
  localparam int GUARD = RADIX_SHIFT - 1;
  function automatic int booth_wi(input int width);
    return width + RADIX_SHIFT;
  endfunction
  function automatic int booth_iters(input int width);
    return (width + RADIX_SHIFT) / RADIX_SHIFT;
  endfunction
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps Q low bits plus q(-1) to a Booth operation and the matching multiple of M.
module booth_recoder import booth_pkg::*; #(
  parameter int WA = 17
) (
  input  logic [RADIX_SHIFT:0] bits,
  input  logic [WA-1:0]        m,
  output op_t                  op,
  output logic [WA-1:0]        mult
);
`ifdef BOOTH_RADIX4_EN
  always_comb op = (bits == 3'b001 || bits == 3'b010) ? OP_ADD1 :
                   bits == 3'b011 ? OP_ADD2 :
                   bits == 3'b100 ? OP_SUB2 :
                   (bits == 3'b101 || bits == 3'b110) ? OP_SUB1 : OP_NONE;
`else
  always_comb op = bits == 2'b01 ? OP_ADD1 : bits == 2'b10 ? OP_SUB1 : OP_NONE;
`endif
  always_comb mult = op == OP_ADD1 ? m :
                     op == OP_SUB1 ? -m :
                     op == OP_ADD2 ? m << 1 :
                     op == OP_SUB2 ? -(m << 1) : '0;
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier, serial operand load, sticky done;
// radix-4 recoding when BOOTH_RADIX4_EN is defined, radix-2 otherwise.
module booth_mult_seq import booth_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int WI = booth_wi(WIDTH);
  localparam int WA = WI + GUARD;
  localparam int N  = booth_iters(WIDTH);
  localparam int CW = $clog2(N + 1);
  state_t          state;
  op_t             op;
  logic [WA-1:0]   a, m, mult, a_sum;
  logic [WI-1:0]   q;
  logic            q_1, sgn, ext_bit;
  logic [CW-1:0]   cnt;
  logic [WA+WI:0]  shifted;
  booth_recoder #(.WA(WA)) u_rec (
    .bits({q[RADIX_SHIFT-1:0], q_1}),
    .m(m),
    .op(op),
    .mult(mult)
  );
  assign ext_bit = sgn & data_in[WIDTH-1];
  assign a_sum   = op == OP_NONE ? a : a + mult;
  assign shifted = $signed({a_sum, q, q_1}) >>> RADIX_SHIFT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      sgn     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD_M;
          sgn   <= sign_mode;
          a     <= '0;
          q     <= '0;
          q_1   <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        LOAD_M: begin
          m     <= {{(WA-WIDTH){ext_bit}}, data_in};
          state <= LOAD_Q;
        end
        LOAD_Q: begin
          q     <= {{(WI-WIDTH){ext_bit}}, data_in};
          q_1   <= 1'b0;
          cnt   <= CW'(N);
          state <= ITER;
        end
        ITER: begin
          a   <= shifted[WA+WI:WI+1];
          q   <= shifted[WI:1];
          q_1 <= shifted[0];
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= shifted[2*WIDTH:1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: random and directed multiplies checked cycle by cycle against an arithmetic model.
module tb_booth_mult_seq;
  localparam int W = 16;
`ifdef BOOTH_RADIX4_EN
  localparam int N = (W + 2) / 2;
`else
  localparam int N = W + 1;
`endif
  logic           clk = 1'b0, reset = 1'b1, start = 1'b0, sign_mode = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           busy, done;
  logic [2*W-1:0] product;
  int             errors = 0, checks = 0;
  logic           mb, md, msm;
  logic [W-1:0]   mm, mq;
  logic [2*W-1:0] mp;
  int             k;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sign_mode(sign_mode),
    .data_in(data_in), .busy(busy), .done(done), .product(product)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    if (sm) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: counts edges since the accepted start, captures operands on the 1st/2nd edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mb <= 1'b0; md <= 1'b0; mp <= '0; k <= 0; msm <= 1'b0; mm <= '0; mq <= '0;
    end else if (start && !mb) begin
      mb <= 1'b1; md <= 1'b0; k <= 0; msm <= sign_mode;
    end else if (mb) begin
      k <= k + 1;
      if (k == 0) mm <= data_in;
      if (k == 1) mq <= data_in;
      if (k == N + 1) begin
        mb <= 1'b0;
        md <= 1'b1;
        mp <= ref_mul(msm, mm, mq);
      end
    end
  end

  always @(negedge clk) if (!reset) begin
    check("busy", busy, mb);
    check("done", done, md);
    check("product", product, mp);
  end

  task automatic op(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y, input logic poke);
    int lat;
    @(negedge clk); start = 1'b1; sign_mode = sm; data_in = W'($urandom);
    @(negedge clk); start = 1'b0; sign_mode = 1'($urandom); data_in = x;
    @(negedge clk); data_in = y;
    @(negedge clk); data_in = W'($urandom);
    lat = 2;
    while (!done && lat < 200) begin
      start = poke && lat == 5;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, N + 2);
  endtask

  task automatic directed(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y, input logic poke, input logic [2*W-1:0] exp);
    op(sm, x, y, poke);
    check("literal_product", product, exp);
    check("literal_model", mp, exp);
  endtask

  initial begin
    logic [W-1:0] corners [5];
    logic [W-1:0] x, y;
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 0);
    @(negedge clk); reset = 1'b0;
    directed(1'b1, 16'hFFFE, 16'h0002, 1'b0, 32'hFFFFFFFC);
    directed(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    directed(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'h00000001);
    directed(1'b1, 16'h8000, 16'h8000, 1'b0, 32'h40000000);
    directed(1'b1, 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    directed(1'b1, 16'h0003, 16'hFFFB, 1'b0, 32'hFFFFFFF1);
    repeat (3) @(negedge clk);
    check("done_sticky", done, 1'b1);
    // Abort an operation mid-iteration: outputs must clear without waiting for a clock edge.
    @(negedge clk); start = 1'b1; sign_mode = 1'b0;
    @(negedge clk); start = 1'b0; data_in = 16'd5;
    @(negedge clk); data_in = 16'd7;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    check("async_product", product, 0);
    @(negedge clk); reset = 1'b0;
    directed(1'b0, 16'd5, 16'd7, 1'b0, 32'd35);
    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      op(1'($urandom), x, y, 1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
